banner_scroller: RTL and testbench
==================================

BANNER_SCROLLER -- requirements
Module: banner_scroller

Interface
REQ-001 SHALL have parameter ROM_W, default 70, meaning banner row width in pixels.
REQ-002 SHALL have parameter ROWS, default 15, meaning banner row count.
REQ-003 SHALL have parameter WIN_W, default 32, meaning visible window width in pixels.
REQ-004 SHALL have parameter SPEED, default 4, meaning frames per one-column scroll step.
REQ-005 SHALL have port clk, input, 1, the single system clock, all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1, single-cycle request to begin scrolling.
REQ-008 SHALL have port stop, input, 1, single-cycle request to halt after the current frame.
REQ-009 SHALL have port rom_address, output, 5, row address to the banner ROM.
REQ-010 SHALL have port rom_data, input, ROM_W, row data from the ROM; bit ROM_W-1 is the leftmost pixel.
REQ-011 SHALL have port pix_valid, output, 1, pixel stream valid.
REQ-012 SHALL have port pix_ready, input, 1, pixel stream sink ready.
REQ-013 SHALL have port pix_data, output, 1, pixel value.
REQ-014 SHALL have port pix_row, output, 4, row index of the current pixel.
REQ-015 SHALL have port pix_col, output, 5, window column of the current pixel.
REQ-016 SHALL have port frame_done, output, 1, one-cycle pulse after the last pixel of a frame is accepted.
REQ-017 SHALL have port busy, output, 1, high in any state except IDLE.

Function
REQ-018 SHALL implement the FSM states IDLE, FETCH, WAIT, LATCH, EMIT and FRAME_END.
- IDLE -> FETCH on start.
- FETCH drives rom_address=row, then -> WAIT.
- WAIT -> LATCH, covering the ROM's one-cycle registered-address latency.
- LATCH copies rom_data into an internal row register, then -> EMIT.
REQ-019 SHALL assert pix_valid in EMIT only, and SHALL hold pix_data, pix_row and pix_col stable while pix_valid=1 and pix_ready=0.
REQ-020 SHALL count a pixel as transferred only on a cycle where pix_valid=1 and pix_ready=1.
REQ-021 SHALL set pix_data to row_reg bit index ROM_W-1-((offset+pix_col) mod ROM_W), so the window wraps from the rightmost banner column back to the leftmost.
REQ-022 SHALL handle the last pixel of a row as follows:
- transfer at pix_col=WIN_W-1 -> FETCH for row+1;
- transfer at row=ROWS-1 -> FRAME_END instead.
REQ-023 SHALL pulse frame_done for one cycle in FRAME_END and increment the frame counter there.
- Frame counter reaching SPEED-1 -> frame counter to 0, offset = (offset+1) mod ROM_W; offset 69 wraps to 0.
REQ-024 SHALL leave FRAME_END to IDLE if a stop is pending, else to FETCH with row=0.
REQ-025 SHALL latch stop into a pending flag at any time while busy; the current frame always completes. Start and stop in the same cycle in IDLE SHALL leave the block in IDLE.
REQ-026 SHALL ignore start while busy.
REQ-027 SHALL retain offset across stop/start; only reset clears offset.
REQ-028 SHALL keep the frame counter and offset within 0..SPEED-1 and 0..ROM_W-1, with no overflow.
REQ-029 SHALL keep rom_address in 0..ROWS-1 at all times.

Reset
REQ-030 SHALL, while rst_n=0 (asynchronously), force:
- state to IDLE;
- rom_address, pix_valid, pix_data, pix_row, pix_col, frame_done and busy to 0;
- offset, frame counter, row register and stop-pending to 0.
REQ-031 SHALL apply reset immediately when it is asserted mid-frame: no partial frame_done, and the first frame after the next start begins at row 0, column 0, offset 0.

Structure
REQ-032 SHALL place the state enumeration and the default ROM_W, ROWS and WIN_W constants in the shared banner package, for reuse by the display driver.
REQ-033 SHALL contain no sub-module; the ROM is instantiated by the parent and connected through rom_address/rom_data.

Verification
REQ-034 SHALL cover a first frame: reset, start, pix_ready=1, banner row 0 = 1111110000001111110000001111111110... (ROM_W bits, MSB leftmost) -> row 0 emits pix_data 1 for cols 0-5, then 0 for cols 6-11; frame_done after 15x32=480 transfers.
REQ-035 SHALL cover backpressure: pix_ready=0 for 5 cycles at row 3 col 10 -> outputs frozen, no column skipped, and the transfer completes at col 10 when ready returns.
REQ-036 SHALL cover scroll and wrap: SPEED=1, run 70 frames -> offset 69, row-0 col 0 equals bit 0 (1) and col 1 equals bit 69 (1); the next frame has offset 0.
REQ-037 SHALL cover stop: stop pulse at row 7 -> frame finishes, frame_done pulses, busy falls the next cycle, and offset is retained on restart.
REQ-038 SHALL cover reset mid-EMIT: rst_n low at row 5 -> all outputs 0 the same cycle; restart begins at row 0, col 0, offset 0.
REQ-039 SHALL cover start while busy: start pulse mid-frame -> no effect on row, col or frame count.

Source files
------------

// File: rtl/banner_scroller_pkg.sv
// Shared banner definitions: default geometry and the scroller state encoding,
// reused by the display driver.
package banner_scroller_pkg;

  localparam int DEF_ROM_W = 70;
  localparam int DEF_ROWS  = 15;
  localparam int DEF_WIN_W = 32;
  localparam int DEF_SPEED = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_LATCH,
    ST_EMIT,
    ST_FRAME_END
  } state_t;

endpackage

// File: rtl/banner_scroller.sv
// Scrolling banner window: fetches one banner row at a time from an external
// ROM and streams a WIN_W-pixel window of it, advancing the offset every SPEED frames.
module banner_scroller
  import banner_scroller_pkg::*;
#(
  parameter int ROM_W = DEF_ROM_W,
  parameter int ROWS  = DEF_ROWS,
  parameter int WIN_W = DEF_WIN_W,
  parameter int SPEED = DEF_SPEED
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  output logic [4:0]       rom_address,
  input  logic [ROM_W-1:0] rom_data,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             pix_data,
  output logic [3:0]       pix_row,
  output logic [4:0]       pix_col,
  output logic             frame_done,
  output logic             busy
);

  localparam int OFF_W = (ROM_W > 1) ? $clog2(ROM_W) : 1;
  localparam int CNT_W = (SPEED > 1) ? $clog2(SPEED) : 1;
  localparam int SUM_W = $clog2(ROM_W + WIN_W);

  state_t           state_q, state_d;
  logic [4:0]       row_q, row_d;
  logic [4:0]       col_q, col_d;
  logic [OFF_W-1:0] offset_q, offset_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [ROM_W-1:0] row_reg_q, row_reg_d;
  logic             stop_pend_q, stop_pend_d;

  logic [SUM_W-1:0] pix_sum;
  logic [OFF_W-1:0] pix_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      offset_q    <= '0;
      frame_cnt_q <= '0;
      row_reg_q   <= '0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      offset_q    <= offset_d;
      frame_cnt_q <= frame_cnt_d;
      row_reg_q   <= row_reg_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  // Window wraps around the banner; a single subtraction suffices while WIN_W <= ROM_W.
  always_comb begin
    pix_sum = SUM_W'(offset_q) + SUM_W'(col_q);
    if (pix_sum >= SUM_W'(ROM_W)) begin
      pix_idx = OFF_W'(pix_sum - SUM_W'(ROM_W));
    end else begin
      pix_idx = OFF_W'(pix_sum);
    end
  end

  assign rom_address = row_q;
  assign pix_valid   = (state_q == ST_EMIT);
  assign pix_data    = (state_q == ST_EMIT) & row_reg_q[OFF_W'(ROM_W-1) - pix_idx];
  assign pix_row     = row_q[3:0];
  assign pix_col     = col_q;
  assign frame_done  = (state_q == ST_FRAME_END);
  assign busy        = (state_q != ST_IDLE);

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    offset_d    = offset_q;
    frame_cnt_d = frame_cnt_q;
    row_reg_d   = row_reg_q;
    stop_pend_d = stop_pend_q | (stop & (state_q != ST_IDLE));

    case (state_q)
      ST_IDLE: begin
        stop_pend_d = 1'b0;
        if (start && !stop) begin
          state_d = ST_FETCH;
          row_d   = '0;
          col_d   = '0;
        end
      end
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT:  state_d = ST_LATCH;
      ST_LATCH: begin
        row_reg_d = rom_data;
        state_d   = ST_EMIT;
      end
      ST_EMIT: begin
        if (pix_ready) begin
          if (col_q == 5'(WIN_W-1)) begin
            col_d = '0;
            if (row_q == 5'(ROWS-1)) begin
              state_d = ST_FRAME_END;
            end else begin
              row_d   = row_q + 5'd1;
              state_d = ST_FETCH;
            end
          end else begin
            col_d = col_q + 5'd1;
          end
        end
      end
      ST_FRAME_END: begin
        if (frame_cnt_q == CNT_W'(SPEED-1)) begin
          frame_cnt_d = '0;
          offset_d    = (offset_q == OFF_W'(ROM_W-1)) ? '0 : offset_q + 1'b1;
        end else begin
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
        row_d = '0;
        col_d = '0;
        if (stop_pend_q || stop) begin
          state_d     = ST_IDLE;
          stop_pend_d = 1'b0;
        end else begin
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_banner_scroller.sv
// Bench for banner_scroller: a default-speed instance and a SPEED=1 instance,
// each checked pixel by pixel against a frame/offset model of the banner.
module tb_banner_scroller;
  import banner_scroller_pkg::*;

  localparam int ROM_W     = DEF_ROM_W;
  localparam int ROWS      = DEF_ROWS;
  localparam int WIN_W     = DEF_WIN_W;
  localparam int FRAME_PIX = ROWS * WIN_W;
  localparam int IW        = $clog2(ROM_W);

  typedef struct {
    bit start;
    bit ready;
    bit exp_busy;
    bit exp_valid;
    int exp_col;
    bit exp_data;
  } vec_t;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b1;
  logic             start_s [2];
  logic             stop_s  [2];
  logic             ready_s [2];
  logic [4:0]       addr_s  [2];
  logic [ROM_W-1:0] rdata_s [2];
  logic             valid_s [2];
  logic             data_s  [2];
  logic [3:0]       row_s   [2];
  logic [4:0]       col_s   [2];
  logic             done_s  [2];
  logic             busy_s  [2];

  logic [ROM_W-1:0] rom [32];

  int n_tests = 0;
  int n_fail  = 0;
  int xfer   [2] = '{0, 0};
  int frames [2] = '{0, 0};

  always #5 clk = ~clk;

  banner_scroller #(.ROM_W(ROM_W), .ROWS(ROWS), .WIN_W(WIN_W), .SPEED(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .stop(stop_s[0]),
    .rom_address(addr_s[0]), .rom_data(rdata_s[0]),
    .pix_valid(valid_s[0]), .pix_ready(ready_s[0]), .pix_data(data_s[0]),
    .pix_row(row_s[0]), .pix_col(col_s[0]), .frame_done(done_s[0]), .busy(busy_s[0])
  );

  banner_scroller #(.ROM_W(ROM_W), .ROWS(ROWS), .WIN_W(WIN_W), .SPEED(1)) u_fast (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .stop(stop_s[1]),
    .rom_address(addr_s[1]), .rom_data(rdata_s[1]),
    .pix_valid(valid_s[1]), .pix_ready(ready_s[1]), .pix_data(data_s[1]),
    .pix_row(row_s[1]), .pix_col(col_s[1]), .frame_done(done_s[1]), .busy(busy_s[1])
  );

  // Registered-address ROM, one per instance.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) rdata_s[i] <= rom[addr_s[i]];
  end

  function automatic int spd(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic logic exp_pix(input int i, input int r, input int c);
    int offs;
    int idx;
    logic [ROM_W-1:0] w;
    offs = (frames[i] / spd(i)) % ROM_W;
    idx  = ROM_W - 1 - ((offs + c) % ROM_W);
    w    = rom[5'(r)];
    return w[IW'(idx)];
  endfunction

  task automatic check(input string name, input int inst, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", name, inst, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input int i, input string tag);
    check({tag, "_addr"},  i, addr_s[i],  0);
    check({tag, "_valid"}, i, valid_s[i], 0);
    check({tag, "_data"},  i, data_s[i],  0);
    check({tag, "_row"},   i, row_s[i],   0);
    check({tag, "_col"},   i, col_s[i],   0);
    check({tag, "_done"},  i, done_s[i],  0);
    check({tag, "_busy"},  i, busy_s[i],  0);
  endtask

  task automatic wait_pix(input int i, input int r, input int c, input int bound);
    int k = 0;
    while (!(valid_s[i] && row_s[i] == 4'(r) && col_s[i] == 5'(c)) && k < bound) begin
      tick();
      k++;
    end
    check($sformatf("reach_r%0d_c%0d", r, c), i,
          valid_s[i] && row_s[i] == 4'(r) && col_s[i] == 5'(c), 1);
  endtask

  task automatic wait_done(input int i, input int bound);
    int k = 0;
    while (!done_s[i] && k < bound) begin
      tick();
      k++;
    end
    check("frame_done_seen", i, done_s[i], 1);
  endtask

  task automatic monitor();
    logic       hold [2];
    logic       hd   [2];
    logic [3:0] hr   [2];
    logic [4:0] hc   [2];
    for (int i = 0; i < 2; i++) begin
      hold[i] = 1'b0; hd[i] = 1'b0; hr[i] = '0; hc[i] = '0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) begin
          xfer[i] = 0; frames[i] = 0; hold[i] = 1'b0;
          continue;
        end
        check("rom_addr_range", i, addr_s[i] < 5'(ROWS), 1);
        if (hold[i]) begin
          check("hold_valid", i, valid_s[i], 1);
          check("hold_row",   i, row_s[i],   hr[i]);
          check("hold_col",   i, col_s[i],   hc[i]);
          check("hold_data",  i, data_s[i],  hd[i]);
        end
        if (valid_s[i]) check("valid_busy", i, busy_s[i], 1);
        if (valid_s[i] && ready_s[i]) begin
          check("pix_row",  i, row_s[i],  xfer[i] / WIN_W);
          check("pix_col",  i, col_s[i],  xfer[i] % WIN_W);
          check("pix_data", i, data_s[i], exp_pix(i, xfer[i] / WIN_W, xfer[i] % WIN_W));
          xfer[i]++;
        end
        if (done_s[i]) begin
          check("frame_xfers", i, xfer[i], FRAME_PIX);
          frames[i]++;
          xfer[i] = 0;
        end
        hold[i] = valid_s[i] && !ready_s[i];
        hd[i] = data_s[i]; hr[i] = row_s[i]; hc[i] = col_s[i];
      end
    end
  endtask

  initial begin : main
    vec_t tbl [20];
    logic [95:0] rnd;
    logic [ROM_W-1:0] pat;
    logic [3:0] r_keep;
    logic [4:0] c_keep;
    int k;

    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0; stop_s[i] = 1'b0; ready_s[i] = 1'b0;
    end
    pat = 70'b1111110000001111110000001111111110_10101010101010101010101010101010_1011;
    for (int r = 0; r < 32; r++) begin
      rnd = {$urandom, $urandom, $urandom};
      rom[5'(r)] = (r < ROWS) ? rnd[ROM_W-1:0] : '0;
    end
    rom[0] = pat;

    tbl[0] = '{0, 1, 0, 0, 0, 0};
    tbl[1] = '{1, 1, 1, 0, 0, 0};
    tbl[2] = '{0, 1, 1, 0, 0, 0};
    tbl[3] = '{0, 1, 1, 0, 0, 0};
    tbl[4] = '{0, 1, 1, 1, 0, 1};
    tbl[5] = '{0, 0, 1, 1, 0, 1};
    tbl[6] = '{0, 0, 1, 1, 0, 1};
    tbl[7] = '{0, 1, 1, 1, 1, 1};
    for (int c = 2; c <= 5; c++) tbl[c+6] = '{0, 1, 1, 1, c, 1};
    tbl[12] = '{0, 1, 1, 1, 6, 0};
    tbl[13] = '{0, 1, 1, 1, 7, 0};
    tbl[14] = '{0, 0, 1, 1, 7, 0};
    for (int c = 8; c <= 11; c++) tbl[c+7] = '{0, 1, 1, 1, c, 0};
    tbl[19] = '{0, 1, 1, 1, 12, 1};

    fork
      monitor();
    join_none

    #2 rst_n = 1'b0;
    repeat (3) tick();
    check_zero(0, "reset");
    check_zero(1, "reset");
    rst_n = 1'b1;

    // First frame, cycle by cycle from IDLE.
    for (int n = 0; n < 20; n++) begin
      start_s[0] = tbl[n].start;
      ready_s[0] = tbl[n].ready;
      tick();
      check($sformatf("tbl%0d_busy", n), 0, busy_s[0], tbl[n].exp_busy);
      check($sformatf("tbl%0d_valid", n), 0, valid_s[0], tbl[n].exp_valid);
      if (tbl[n].exp_valid) begin
        check($sformatf("tbl%0d_row", n), 0, row_s[0], 0);
        check($sformatf("tbl%0d_col", n), 0, col_s[0], tbl[n].exp_col);
        check($sformatf("tbl%0d_data", n), 0, data_s[0], tbl[n].exp_data);
      end
    end
    start_s[0] = 1'b0;
    ready_s[0] = 1'b1;
    wait_done(0, 1000);
    tick();
    check("after_done_pulse", 0, done_s[0], 0);
    check("after_done_busy",  0, busy_s[0], 1);
    check("after_done_row",   0, row_s[0],  0);

    // Backpressure at row 3 col 10.
    wait_pix(0, 3, 10, 400);
    ready_s[0] = 1'b0;
    for (int n = 0; n < 5; n++) begin
      tick();
      check("bp_valid", 0, valid_s[0], 1);
      check("bp_row",   0, row_s[0],   3);
      check("bp_col",   0, col_s[0],   10);
    end
    ready_s[0] = 1'b1;
    tick();
    check("bp_resume_col", 0, col_s[0], 11);

    // Start while busy is ignored.
    r_keep = row_s[0];
    c_keep = col_s[0];
    ready_s[0] = 1'b0;
    start_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    check("busy_start_row",  0, row_s[0],  r_keep);
    check("busy_start_col",  0, col_s[0],  c_keep);
    check("busy_start_busy", 0, busy_s[0], 1);

    // Random backpressure with stray start pulses across several frames.
    for (int n = 0; n < 6000; n++) begin
      ready_s[0] = ($urandom_range(3) != 0);
      start_s[0] = ($urandom_range(199) == 0);
      tick();
    end
    start_s[0] = 1'b0;
    check("random_frames_min", 0, frames[0] >= 6, 1);

    // Stop at row 7: frame completes, then IDLE.
    ready_s[0] = 1'b1;
    wait_pix(0, 7, 0, 1200);
    stop_s[0] = 1'b1;
    tick();
    stop_s[0] = 1'b0;
    check("stop_still_busy", 0, busy_s[0], 1);
    wait_done(0, 600);
    tick();
    check("stop_busy_fell",  0, busy_s[0],  0);
    check("stop_valid_low",  0, valid_s[0], 0);
    repeat (3) tick();
    check("stop_stays_idle", 0, busy_s[0], 0);

    start_s[0] = 1'b1;
    stop_s[0]  = 1'b1;
    tick();
    start_s[0] = 1'b0;
    stop_s[0]  = 1'b0;
    check("start_stop_idle", 0, busy_s[0], 0);

    start_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    check("restart_busy", 0, busy_s[0], 1);
    wait_pix(0, 0, 0, 10);
    check("restart_offset_kept", 0, data_s[0], exp_pix(0, 0, 0));

    // Reset in the middle of row 5.
    wait_pix(0, 5, 3, 800);
    rst_n = 1'b0;
    #1;
    check_zero(0, "midreset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("post_reset_idle", 0, busy_s[0], 0);
    start_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    wait_pix(0, 0, 0, 10);
    check("post_reset_c0", 0, data_s[0], 1);
    wait_pix(0, 0, 6, 10);
    check("post_reset_c6", 0, data_s[0], 0);

    // SPEED=1: offset reaches ROM_W-1 on the 70th frame, then wraps to 0.
    ready_s[1] = 1'b1;
    start_s[1] = 1'b1;
    tick();
    start_s[1] = 1'b0;
    k = 0;
    while (frames[1] < 69 && k < 40000) begin
      tick();
      k++;
    end
    check("wrap_frames_reached", 1, frames[1], 69);
    wait_pix(1, 0, 0, 20);
    check("off69_c0", 1, data_s[1], 1);
    tick();
    check("off69_c1", 1, data_s[1], 1);
    wait_pix(1, 0, 6, 10);
    check("off69_c6", 1, data_s[1], 1);
    tick();
    check("off69_c7", 1, data_s[1], 0);
    wait_done(1, 600);
    wait_pix(1, 0, 0, 20);
    check("off0_c0", 1, data_s[1], 1);
    wait_pix(1, 0, 6, 10);
    check("off0_c6", 1, data_s[1], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
